// File: rtl/snoop_bus_arbiter.sv
// Snoopy bus arbiter: write-back (op=1) transfers beat read-miss (op=0) transfers,
// round-robin within each class, fixed tenure per grant, optional bus turnaround.
module snoop_bus_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic                   plusclk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     bus_req,
  input  logic [NUM_REQ-1:0]     bus_req_op,
  input  logic [4*NUM_REQ-1:0]   bus_req_clc,
  output logic [NUM_REQ-1:0]     bus_get,
  output logic [ID_W-1:0]        bus_owner,
  output logic                   bus_busy,
  output logic                   grant_op
);

  localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [1:0]        turn_cnt;
  logic [ID_W-1:0]   ptr_addr;
  logic [ID_W-1:0]   ptr_data;

  logic                 any_data;
  logic                 arb_found;
  logic                 owner_req;
  logic                 tenure_end;
  logic                 arb_now;
  logic [NUM_REQ-1:0]   cand;
  logic [2*NUM_REQ-1:0] cand_rot;
  logic [ID_W-1:0]      arb_ptr;
  logic [ID_W-1:0]      arb_idx;
  logic [ID_W-1:0]      arb_ptr_next;
  logic [ID_W:0]        sum;
  logic [3:0]           arb_clc;

  always_comb begin
    any_data  = |(bus_req & bus_req_op);
    cand      = any_data ? (bus_req & bus_req_op) : (bus_req & ~bus_req_op);
    arb_ptr   = any_data ? ptr_data : ptr_addr;
    // Rotate the candidate vector so the search always starts at bit 0.
    cand_rot  = {cand, cand} >> arb_ptr;
    arb_found = 1'b0;
    sum       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!arb_found && cand_rot[i]) begin
        arb_found = 1'b1;
        sum       = {1'b0, arb_ptr} + (ID_W+1)'(i);
      end
    end
    if (sum >= NREQ) sum = sum - NREQ;
    arb_idx      = sum[ID_W-1:0];
    arb_ptr_next = (arb_idx == ID_W'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;

    arb_clc = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (arb_idx == ID_W'(j)) arb_clc = bus_req_clc[4*j +: 4];
    end
    if (arb_clc == 4'd0) arb_clc = 4'd1;

    owner_req  = |(bus_req & bus_get);
    tenure_end = (state == GRANT) && ((cnt == 4'd1) || !owner_req);
    // The last turnaround edge, or a tenure exit with no turnaround, arbitrates
    // exactly as IDLE would, so the gap between grants is TURN_CYCLES cycles.
    arb_now    = (state == IDLE) ||
                 ((state == TURN) && (turn_cnt == 2'd1)) ||
                 (tenure_end && (TURN_CYCLES == 0));
  end

  always_ff @(posedge plusclk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      turn_cnt  <= '0;
      ptr_addr  <= '0;
      ptr_data  <= '0;
      bus_get   <= '0;
      bus_owner <= '0;
      bus_busy  <= 1'b0;
      grant_op  <= 1'b0;
    end else begin
      case (state)
        GRANT: begin
          if (tenure_end) begin
            bus_get   <= '0;
            bus_owner <= '0;
            bus_busy  <= 1'b0;
            grant_op  <= 1'b0;
            cnt       <= '0;
            state     <= (TURN_CYCLES > 0) ? TURN : IDLE;
            turn_cnt  <= 2'(TURN_CYCLES);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        TURN: begin
          if (turn_cnt == 2'd1) state <= IDLE;
          else                  turn_cnt <= turn_cnt - 1'b1;
        end
        default: ;
      endcase

      if (arb_now && arb_found) begin
        bus_get          <= '0;
        bus_get[arb_idx] <= 1'b1;
        bus_owner        <= arb_idx;
        bus_busy         <= 1'b1;
        grant_op         <= any_data;
        cnt              <= arb_clc;
        state            <= GRANT;
        if (any_data) ptr_data <= arb_ptr_next;
        else          ptr_addr <= arb_ptr_next;
      end
    end
  end

endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
- Arbitrates the shared snoopy bus between NUM_REQ L1 cache control units.
- Each control unit asks for the bus with bus_req, bus_req_op and bus_req_clc, and owns the bus while its bus_get bit is high.
- Write-back data transfers (op=1) take priority over read-miss address transfers (op=0). Round-robin applies within each class.
- Grant tenure runs for the number of cycles the requester declares, followed by a configurable bus turnaround.

Parameters:
- NUM_REQ, 4, number of requesting cache controllers (2..8).
- ID_W, 2, width of the owner index; must satisfy 2**ID_W >= NUM_REQ.
- TURN_CYCLES, 1, idle cycles inserted between tenures (0..3).

Ports:
- plusclk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- bus_req  in  NUM_REQ  per-requester request level; held until granted.
- bus_req_op  in  NUM_REQ  per-requester class: 0=address (read miss), 1=data (write-back/priority write-back).
- bus_req_clc  in  4*NUM_REQ  per-requester tenure length in cycles; requester i uses bits [4i+3:4i].
- bus_get  out  NUM_REQ  one-hot grant, registered.
- bus_owner  out  ID_W  index of the current grantee; 0 when idle.
- bus_busy  out  1  high while any grant is active.
- grant_op  out  1  latched class of the current tenure.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state=IDLE, tenure counter=0, both round-robin pointers=0. Reset asserted mid-tenure drops bus_get immediately; the tenure is not resumed.
- States: IDLE, GRANT, TURN.
- IDLE, when any bus_req bit is high at a rising edge:
  - Selection: if any active requester has op=1, choose among op=1 requesters; otherwise choose among op=0 requesters.
  - Round-robin within the chosen class: search starts at (that class's pointer), wrapping modulo NUM_REQ; the first active requester wins.
  - Registered on the same edge: bus_get[w]=1, bus_owner=w, bus_busy=1, grant_op=class, counter=clc_w (0 is treated as 1).
  - The chosen class's pointer becomes (w+1) mod NUM_REQ; the other pointer is unchanged.
  - Next state: GRANT.
- Latency: request sampled at edge k drives bus_get high after edge k, i.e. 1 cycle from request to grant.
- GRANT:
  - Counter decrements each edge.
  - When counter==1, or the owner deasserts bus_req, the next edge clears bus_get/bus_busy/bus_owner/grant_op.
  - Next state is TURN if TURN_CYCLES>0, else IDLE. With TURN_CYCLES=0, the exit edge itself performs the IDLE arbitration, giving back-to-back grants.
  - Tenure length: bus_get is high for exactly max(clc,1) cycles unless the owner releases early.
- TURN: counts TURN_CYCLES cycles with all outputs 0, then goes to IDLE. Requests arriving here wait and are not lost.
- Inputs are ignored during GRANT:
  - bus_req_op and bus_req_clc changes from non-owners have no effect.
  - The owner's clc/op are latched at grant; later changes are ignored.
  - No preemption: a new op=1 request waits for the current tenure to end.
- Starvation bound: with continuous op=1 traffic, op=0 requesters wait. This is accepted; the cache protocol bounds write-backs.
- Invariants: bus_get is one-hot or zero; bus_busy == |bus_get.
- Simultaneous events: the owner dropping its request and the counter expiring on the same cycle end the tenure once, with no extra cycle.

Test Plan:
1. Single read miss: after reset release, req[1]=1, op=0, clc=2 → bus_get=4'b0010 one cycle later, high 2 cycles, bus_owner=1, grant_op=0; then 1 idle cycle (TURN_CYCLES=1).
2. Priority: req[0] (op=0, clc=2) and req[2] (op=1, clc=2) rise the same cycle → req[2] granted first with grant_op=1; req[0] granted after the 2-cycle tenure plus 1 turnaround cycle.
3. Round-robin: all four requesters op=0, clc=1, requests held → grant order 0,1,2,3,0, each separated by 1 idle cycle; the pointer wraps from 3 to 0.
4. Early release and clc=0: req[3] clc=4 drops its request after 2 granted cycles → bus_get[3] low on the next edge. A later request with clc=0 → exactly 1 grant cycle.
5. Async reset mid-tenure: rst=0 between clock edges during a clc=4 grant → all outputs 0 immediately. After release with no requests → bus_busy stays 0.
6. TURN_CYCLES=0 build: req[0] and req[1] both op=1, clc=2 → grants back-to-back (0 then 1) with no gap; bus_get is never two-hot.
